pixel_pad_tx: RTL and testbench
===============================

PIXEL_PAD_TX -- requirements
Module: pixel_pad_tx

Interface
REQ-001 SHALL: clk  input  1  operating clock; single clock domain.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL: i_valid  input  1  upstream pixel valid.
REQ-004 SHALL: o_ready  output  1  block accepts upstream pixel this cycle.
REQ-005 SHALL: i_x  input  8  unpadded unsigned pixel, row-major, 512 per row.
REQ-006 SHALL: i_last  input  1  qualifies the pixel as the last pixel of the frame.
REQ-007 SHALL: i_ready  input  1  downstream (convolution block) ready.
REQ-008 SHALL: o_valid  output  1  padded output pixel valid.
REQ-009 SHALL: o_x  output  8  padded output pixel.
REQ-010 SHALL: o_err  output  1  sticky flag for a misplaced i_last.

Function
REQ-011 SHALL: the block converts an H x 512 image into an (H+2) x 514 zero-padded stream: one zero top row, each image row framed as 0, 512 pixels, 0, then one zero bottom row.
REQ-012 SHALL: upstream transfer = i_valid && o_ready; downstream transfer = o_valid && i_ready.
REQ-013 SHALL: o_valid/o_x come from a single output register; the register loads when !o_valid || i_ready, so o_x stays stable while o_valid && !i_ready.
REQ-014 SHALL: o_ready = (state == BODY) && (!o_valid || i_ready); pad pixels never consume upstream data.
REQ-015 SHALL: latency is 1 cycle, from upstream transfer (or pad generation) to the pixel appearing on o_x with o_valid.
REQ-016 SHALL: the FSM has states IDLE, TOP_PAD, LEFT_PAD, BODY, RIGHT_PAD, BOTTOM_PAD.
REQ-017 SHALL: IDLE -> TOP_PAD when i_valid is 1; the pixel is not consumed.
REQ-018 SHALL: TOP_PAD emits 514 zeros, one per output-register load, then -> LEFT_PAD.
REQ-019 SHALL: LEFT_PAD emits one zero, then -> BODY.
REQ-020 SHALL: BODY forwards pixels; a 10-bit column counter runs 0..511 and advances only on upstream transfer.
REQ-021 SHALL: after the transfer at column 511 -> RIGHT_PAD; a latched last-row flag = i_last at that transfer.
REQ-022 SHALL: RIGHT_PAD emits one zero, then -> BOTTOM_PAD if last-row flag is set, else -> LEFT_PAD.
REQ-023 SHALL: BOTTOM_PAD emits 514 zeros, then -> IDLE; a new frame may start on the next cycle.
REQ-024 SHALL: i_last asserted on a transfer at column != 511 sets o_err and is otherwise ignored; the frame continues.
REQ-025 SHALL: i_valid low in BODY produces no output load; o_valid drops once the current pixel is taken, and no pad is inserted.
REQ-026 SHALL: when downstream stalls, the FSM and counters hold; pad emission also advances only on register load.
REQ-027 SHALL: the frame height is unbounded; only i_last terminates a frame.

Reset
REQ-028 SHALL: reset forces state = IDLE, column counter = 0, last-row flag = 0, o_valid = 0, o_x = 0, o_err = 0; o_ready = 0 during reset.
REQ-029 SHALL: reset mid-frame discards the partial frame; no bottom pad is emitted; the next frame starts with a top pad.

Structure
REQ-030 SHALL: shared package pixel_stream_pkg holds IMAGE_WIDTH = 512, PADDED_WIDTH = 514, PIXEL_DATAW = 8, and the FSM state enum.
REQ-031 SHALL: one sub-module, pixel_out_reg (valid/data output register with load = !o_valid || i_ready); the FSM and counters stay in pixel_pad_tx.

Verification
REQ-032 SHALL: 2x512 image, i_valid and i_ready always 1 -> 2056 outputs; outputs 0..514 are 0; outputs 515..1026 equal row0; outputs 1027,1028 are 0; outputs 1541..2055 are 0.
REQ-033 SHALL: i_ready low 5 cycles at row0 column 100 -> o_x holds pixel 100 with o_valid = 1; sequence is lossless and duplicate-free.
REQ-034 SHALL: i_valid low 7 cycles at column 300 -> no extra zeros; the 514-pixel row stays intact; o_err = 0.
REQ-035 SHALL: i_last = 1 at row0 column 100 of a 3-row image -> o_err = 1 next cycle; 5x514 outputs still emitted.
REQ-036 SHALL: reset at row1 column 200, then a 1x512 all-255 image -> o_err = 0 and exactly 1542 outputs after reset; row of 0, 255 x 512, 0 between zero rows.
REQ-037 SHALL: back-to-back frames with 1-row images -> second top pad begins one cycle after the first bottom pad ends; 3084 outputs total.

Source files
------------

// File: rtl/pixel_stream_pkg.sv
// Shared constants and FSM state type for the zero-padding pixel stream.
package pixel_stream_pkg;

  localparam int IMAGE_WIDTH  = 512;
  localparam int PADDED_WIDTH = 514;
  localparam int PIXEL_DATAW  = 8;
  localparam int COL_W        = 10;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    TOP_PAD    = 3'd1,
    LEFT_PAD   = 3'd2,
    BODY       = 3'd3,
    RIGHT_PAD  = 3'd4,
    BOTTOM_PAD = 3'd5
  } pad_state_t;

endpackage

// File: rtl/pixel_out_reg.sv
// Single valid/data output register feeding the downstream block.
// Handshake: a pixel moves downstream on a cycle where o_valid && i_ready.
// The register reloads whenever it is empty or its content is being taken,
// so o_x is held stable while o_valid && !i_ready.
module pixel_out_reg
  import pixel_stream_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_emit,
  input  logic [PIXEL_DATAW-1:0] i_data,
  input  logic                   i_ready,
  output logic                   o_load,
  output logic                   o_valid,
  output logic [PIXEL_DATAW-1:0] o_x
);

  logic                   r_valid;
  logic [PIXEL_DATAW-1:0] r_x;

  assign o_load  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_x     = r_x;

  // Output register: capture the next pixel (or a bubble) on every load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_x     <= '0;
    end else if (o_load) begin
      r_valid <= i_emit;
      r_x     <= i_data;
    end
  end

endmodule

// File: rtl/pixel_pad_tx.sv
// Wraps an H x 512 image stream with a one-pixel zero border, producing an
// (H+2) x 514 stream. Pad pixels are generated locally and never consume
// upstream data; everything advances only when the output register loads.
module pixel_pad_tx
  import pixel_stream_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [PIXEL_DATAW-1:0] i_x,
  input  logic                   i_last,
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic [PIXEL_DATAW-1:0] o_x,
  output logic                   o_err
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [COL_W-1:0] PAD_LAST = COL_W'(PADDED_WIDTH - 1);

  pad_state_t             r_state;
  pad_state_t             w_state_n;
  logic [COL_W-1:0]       r_col;
  logic [COL_W-1:0]       w_col_n;
  logic [COL_W-1:0]       r_pad;
  logic [COL_W-1:0]       w_pad_n;
  logic                   r_last_row;
  logic                   w_last_row_n;
  logic                   r_err;
  logic                   w_err_n;
  logic                   w_load;
  logic                   w_emit;
  logic [PIXEL_DATAW-1:0] w_data;
  logic                   w_up_ready;

  pixel_out_reg u_out_reg (
    .clk     (clk),
    .reset   (reset),
    .i_emit  (w_emit),
    .i_data  (w_data),
    .i_ready (i_ready),
    .o_load  (w_load),
    .o_valid (o_valid),
    .o_x     (o_x)
  );

  // Upstream is only accepted in BODY, and never while reset is held.
  assign o_ready = w_up_ready && !reset;
  assign o_err   = r_err;

  // State, counters, last-row flag and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_col      <= '0;
      r_pad      <= '0;
      r_last_row <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_col      <= w_col_n;
      r_pad      <= w_pad_n;
      r_last_row <= w_last_row_n;
      r_err      <= w_err_n;
    end
  end

  // Next-state logic and selection of what the output register loads.
  always_comb begin
    w_state_n    = r_state;
    w_col_n      = r_col;
    w_pad_n      = r_pad;
    w_last_row_n = r_last_row;
    w_err_n      = r_err;
    w_emit       = 1'b0;
    w_data       = '0;
    w_up_ready   = 1'b0;

    case (r_state)
      IDLE: begin
        // The waiting pixel is left untouched; it is consumed in BODY.
        if (i_valid) begin
          w_state_n = TOP_PAD;
        end
      end

      TOP_PAD: begin
        if (w_load) begin
          w_emit = 1'b1;
          if (r_pad == PAD_LAST) begin
            w_pad_n   = '0;
            w_state_n = LEFT_PAD;
          end else begin
            w_pad_n = r_pad + COL_W'(1);
          end
        end
      end

      LEFT_PAD: begin
        if (w_load) begin
          w_emit    = 1'b1;
          w_state_n = BODY;
        end
      end

      BODY: begin
        w_up_ready = w_load;
        if (i_valid && w_load) begin
          w_emit = 1'b1;
          w_data = i_x;
          if (r_col == COL_LAST) begin
            w_col_n      = '0;
            w_last_row_n = i_last;
            w_state_n    = RIGHT_PAD;
          end else begin
            w_col_n = r_col + COL_W'(1);
            // A frame end mid-row is flagged and otherwise ignored.
            if (i_last) begin
              w_err_n = 1'b1;
            end
          end
        end
      end

      RIGHT_PAD: begin
        if (w_load) begin
          w_emit    = 1'b1;
          w_state_n = r_last_row ? BOTTOM_PAD : LEFT_PAD;
        end
      end

      BOTTOM_PAD: begin
        if (w_load) begin
          w_emit = 1'b1;
          if (r_pad == PAD_LAST) begin
            w_pad_n      = '0;
            w_last_row_n = 1'b0;
            w_state_n    = IDLE;
          end else begin
            w_pad_n = r_pad + COL_W'(1);
          end
        end
      end

      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pixel_pad_tx.sv
// Randomized bench for pixel_pad_tx: a frame-level model fills an expected
// queue of padded pixels and every downstream transfer is scored against it.
module tb_pixel_pad_tx;

  logic       clk;
  logic       reset;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_x;
  logic       i_last;
  logic       i_ready;
  logic       o_valid;
  logic [7:0] o_x;
  logic       o_err;

  pixel_pad_tx dut (
    .clk     (clk),
    .reset   (reset),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_x     (i_x),
    .i_last  (i_last),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_x     (o_x),
    .o_err   (o_err)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;
  int out_cnt = 0;
  int cyc = 0;
  int c_a = -1;
  int c_b = -1;
  bit rnd_ready = 1'b0;
  bit forced = 1'b0;
  int stall_left = 0;
  int stall_at = -1;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Padded frame: 514 zeros, then per row 0 / pixels / 0, then 514 zeros.
  task automatic model_frame(input logic [7:0] px[$], input int nrows);
    for (int i = 0; i < 514; i++) exp_q.push_back(16'h0);
    for (int r = 0; r < nrows; r++) begin
      exp_q.push_back(16'h0);
      for (int c = 0; c < 512; c++) exp_q.push_back({8'h0, px[r*512 + c]});
      exp_q.push_back(16'h0);
    end
    for (int i = 0; i < 514; i++) exp_q.push_back(16'h0);
  endtask

  // ---------------- downstream ready driver ----------------
  always @(posedge clk) begin
    #1;
    if (stall_left > 0) begin
      i_ready = 1'b0;
      forced = 1'b1;
      stall_left--;
    end else if (stall_at >= 0 && out_cnt == stall_at && o_valid) begin
      i_ready = 1'b0;
      forced = 1'b1;
      stall_left = 4;
      stall_at = -1;
    end else begin
      forced = 1'b0;
      i_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    logic [15:0] e;
    cyc++;
    if (!reset) begin
      if (forced) chk("stall_valid", {15'h0, o_valid}, 16'h1);
      if (o_valid) begin
        e = (exp_q.size() > 0) ? exp_q[0] : 16'hFFFF;
        if (i_ready) begin
          chk("pixel", {8'h0, o_x}, e);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          if (out_cnt == 1541) c_a = cyc;
          if (out_cnt == 1542) c_b = cyc;
          out_cnt++;
        end else begin
          chk("hold", {8'h0, o_x}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_px(input logic [7:0] x, input logic last, input int gap);
    bit acc;
    int t;
    if (gap > 0) begin
      i_valid = 1'b0;
      repeat (gap) tick();
    end
    i_valid = 1'b1;
    i_x = x;
    i_last = last;
    t = 0;
    acc = 1'b0;
    while (!acc && t < 20000) begin
      @(negedge clk);
      acc = o_ready;
      tick();
      t++;
    end
    if (!acc) chk("accept_timeout", {15'h0, acc}, 16'h1);
  endtask

  // fill: 0 random, 1 all-255. bad_idx: pixel carrying a stray i_last.
  // gap_idx/gap_len: fixed idle gap before that pixel. rnd_gap: random gaps.
  // abort_idx: pixel index at which reset is applied instead.
  task automatic send_frame(input int nrows, input int fill, input int bad_idx,
                            input int gap_idx, input int gap_len, input int rnd_gap,
                            input int abort_idx);
    logic [7:0] px[$];
    int n;
    int g;
    n = nrows * 512;
    for (int i = 0; i < n; i++) px.push_back(fill ? 8'hFF : 8'($urandom_range(0, 255)));
    model_frame(px, nrows);
    for (int i = 0; i < n; i++) begin
      if (i == abort_idx) begin
        i_valid = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b0;
        return;
      end
      g = (i == gap_idx) ? gap_len : (rnd_gap ? $urandom_range(0, 2) : 0);
      send_px(px[i], (i == n - 1) || (i == bad_idx), g);
      if (i == bad_idx) chk("err_set", {15'h0, o_err}, 16'h1);
    end
    i_last = 1'b0;
  endtask

  task automatic drain(input int exp_total);
    int t;
    t = 0;
    i_valid = 1'b0;
    while (exp_q.size() > 0 && t < 20000) begin
      tick();
      t++;
    end
    chk("drain", 16'(exp_q.size()), 16'h0);
    repeat (3) tick();
    chk("count", 16'(out_cnt), 16'(exp_total));
    out_cnt = 0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b1;
    i_valid = 1'b0;
    i_x = '0;
    i_last = 1'b0;
    i_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_ready", {15'h0, o_ready}, 16'h0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", {15'h0, o_valid}, 16'h0);
    chk("rst_x", {8'h0, o_x}, 16'h0);
    chk("rst_err", {15'h0, o_err}, 16'h0);
    tick();

    // 2-row frame at full rate.
    send_frame(2, 0, -1, -1, 0, 0, -1);
    drain(2056);

    // Downstream stall of 5 cycles at row0 column 100.
    stall_at = 615;
    send_frame(2, 0, -1, -1, 0, 0, -1);
    drain(2056);

    // Upstream gap of 7 cycles at column 300: no extra pad.
    send_frame(1, 0, -1, 300, 7, 0, -1);
    drain(1542);
    chk("gap_err", {15'h0, o_err}, 16'h0);

    // Stray i_last at row0 column 100 of a 3-row frame.
    send_frame(3, 0, 100, -1, 0, 0, -1);
    drain(2570);
    chk("err_sticky", {15'h0, o_err}, 16'h1);

    // Reset at row1 column 200, then an all-255 single-row frame.
    send_frame(3, 0, -1, -1, 0, 0, 712);
    out_cnt = 0;
    chk("abort_err", {15'h0, o_err}, 16'h0);
    send_frame(1, 1, -1, -1, 0, 0, -1);
    drain(1542);
    chk("after_rst_err", {15'h0, o_err}, 16'h0);

    // Back-to-back single-row frames.
    c_a = -1;
    c_b = -1;
    send_frame(1, 0, -1, -1, 0, 0, -1);
    send_frame(1, 0, -1, -1, 0, 0, -1);
    drain(3084);
    chk("b2b_gap", 16'(c_b - c_a), 16'h2);

    // Random upstream gaps and downstream backpressure.
    rnd_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      int nr;
      nr = $urandom_range(1, 3);
      send_frame(nr, 0, -1, -1, 0, 1, -1);
      drain((nr + 2) * 514);
    end
    rnd_ready = 1'b0;
    chk("final_err", {15'h0, o_err}, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
